// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Loads a length-prefixed byte stream into instruction memory,
//               holding the CPU in reset until a load completes cleanly.
//               Optional trailing checksum byte: LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter int unsigned        A_WIDTH   = 32,
  parameter int unsigned        D_WIDTH   = 8,
  parameter logic [A_WIDTH-1:0] BASE_ADDR = A_WIDTH'(32'hBFC00000),
  parameter int unsigned        MAX_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cpu_rst
);

  localparam int unsigned IDX_W = $clog2(MAX_BYTES + 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    FIN  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    FIN  = 3'd4
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [1:0]           hcnt_q, hcnt_d;
  logic [31:0]          len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 we_q, we_d;
  logic [A_WIDTH-1:0]   addr_q, addr_d;
  logic [D_WIDTH-1:0]   wdata_q, wdata_d;
  logic                 w_loading;
  logic                 w_accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  always_comb begin
    w_loading = (state_q == HDR) || (state_q == DATA);
`ifdef LOADER_CHECKSUM_EN
    w_loading = w_loading || (state_q == CHK);
`endif
  end

  assign w_accept = in_valid && w_loading;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = HDR;
          hcnt_d  = 2'd0;
          len_d   = 32'd0;
          idx_d   = '0;
          err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
`endif
        end
      end
      HDR: begin
        if (w_accept) begin
          // Little-endian: shift in from the top so the first byte ends at [7:0]
          len_d  = {in_data, len_q[31:8]};
          hcnt_d = hcnt_q + 2'd1;
          if (hcnt_q == 2'd3) begin
            if (len_d == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = FIN;
`endif
            end else if (len_d > MAX_BYTES) begin
              state_d = FIN;
              err_d   = 1'b1;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (w_accept) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + A_WIDTH'(idx_q);
          wdata_d = D_WIDTH'(in_data);
          idx_d   = idx_q + IDX_W'(1);
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          if (32'(idx_q) + 32'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = FIN;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (w_accept) begin
          err_d   = (in_data != sum_q);
          state_d = FIN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= 2'd0;
      len_q   <= 32'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign in_ready  = w_loading;
  assign busy      = w_loading;
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign cpu_rst   = !((state_q == FIN) && !err_q);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Randomized self-checking bench for instr_loader against a
//               stream-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

  localparam int unsigned MAXB = 4096;
  localparam logic [31:0] BASE = 32'hBFC00000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done, err, cpu_rst;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  stream[$];
  logic [31:0] exp_addr;
  logic [7:0]  exp_wd;

  instr_loader #(
    .A_WIDTH  (32),
    .D_WIDTH  (8),
    .BASE_ADDR(BASE),
    .MAX_BYTES(MAXB)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_rst  (cpu_rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Header + n random payload bytes (+ trailer, correct or off by one)
  task automatic build(input int n, input bit good);
    logic [31:0] nn;
    logic [7:0]  s, b;
    nn = n;
    s  = 8'd0;
    stream.delete();
    for (int i = 0; i < 4; i++) stream.push_back(nn[8*i +: 8]);
    if (nn <= MAXB) begin
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        stream.push_back(b);
        s = s + b;
      end
      if (CHK_EN) stream.push_back(good ? s : s + 8'd1);
    end
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random stalls
  task automatic run_load(input int mode);
    logic [31:0] n;
    logic [7:0]  sum;
    bit          ovf, exp_err, v;
    int          consumed, pos, cyc, wr;
    n   = {stream[3], stream[2], stream[1], stream[0]};
    ovf = (n > MAXB);
    sum = 8'd0;
    consumed = ovf ? 4 : 4 + int'(n) + (CHK_EN ? 1 : 0);
    if (!ovf) for (int i = 0; i < int'(n); i++) sum = sum + stream[4+i];
    exp_err = ovf || (CHK_EN && stream[4+int'(n)] != sum);

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("we_after_start", mem_we, 0);
    pos = 0; cyc = 0; wr = 0;
    while (pos < consumed && cyc < consumed * 4 + 20) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      check("ready_loading", in_ready, 1);
      check("done_loading", done, 0);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 99) >= 30);
      in_valid = v;
      in_data  = v ? stream[pos] : 8'($urandom);
      @(posedge clk); #1;
      if (mem_we === 1'b1) wr++;
      if (v && !ovf && pos >= 4 && pos < 4 + int'(n)) begin
        exp_addr = BASE + 32'(pos - 4);
        exp_wd   = stream[pos];
        check("we_write", mem_we, 1);
      end else begin
        check("we_idle", mem_we, 0);
      end
      check("addr", mem_addr, exp_addr);
      check("wdata", mem_wdata, exp_wd);
      if (v) pos++;
      cyc++;
    end
    if (pos < consumed) check("timeout", pos, consumed);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("done_fin", done, 1);
    check("err_fin", err, exp_err);
    check("cpu_rst_fin", cpu_rst, exp_err);
    check("busy_fin", busy, 0);
    check("ready_fin", in_ready, 0);
    @(posedge clk); #1;
    check("we_after_fin", mem_we, 0);
    check("done_hold", done, 1);
    check("write_count", wr, ovf ? 0 : n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_addr = BASE; exp_wd = 8'd0;

`ifdef LOADER_CHECKSUM_EN
    stream = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06};
    run_load(0);
    check("chk_good_err", err, 0);
    stream = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07};
    run_load(0);
    check("chk_bad_err", err, 1);
`else
    stream = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
    run_load(0);
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load(0);
`endif
    stream = '{8'h01, 8'h10, 8'h00, 8'h00};
    run_load(2);
    build(3, 1'b1);
    run_load(1);

    // Reset in the middle of a 4-byte payload
    build(4, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = stream[i];
      @(negedge clk);
    end
    check("mid_we", mem_we, 1);
    check("mid_addr", mem_addr, BASE + 32'd1);
    in_valid = 1'b1; in_data = stream[6]; rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("mrst_we", mem_we, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_cpu_rst", cpu_rst, 1);
    check("mrst_addr", mem_addr, BASE);
    check("mrst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    exp_addr = BASE; exp_wd = 8'd0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    build(4, 1'b1);
    run_load(0);

    build(int'(MAXB), 1'b1);
    run_load(0);
    build(int'(MAXB) + 1, 1'b1);
    run_load(0);
    for (int t = 0; t < 25; t++) begin
      build(int'($urandom_range(0, 40)), bit'($urandom_range(0, 1)));
      run_load(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32: memory address width.
REQ-002 SHALL have parameter D_WIDTH, default 8: memory data width, one byte per write.
REQ-003 SHALL have parameter BASE_ADDR, default 32'hBFC00000: address of the first program byte.
REQ-004 SHALL have parameter MAX_BYTES, default 4096: instruction memory capacity in bytes.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that begins a load.
REQ-008 SHALL have port in_valid, input, 1: in_data holds a valid stream byte.
REQ-009 SHALL have port in_data, input, 8: stream byte.
REQ-010 SHALL have port in_ready, output, 1: loader accepts a byte this cycle.
REQ-011 SHALL have port mem_we, output, 1: byte write strobe to instruction memory.
REQ-012 SHALL have port mem_addr, output, A_WIDTH: byte write address.
REQ-013 SHALL have port mem_wdata, output, D_WIDTH: byte write data.
REQ-014 SHALL have port busy, output, 1: a load is in progress.
REQ-015 SHALL have port done, output, 1: the last load has finished, successfully or not.
REQ-016 SHALL have port err, output, 1: the last load failed.
REQ-017 SHALL have port cpu_rst, output, 1: holds the processor in reset.

Function
REQ-018 SHALL implement FSM states IDLE, HDR, DATA, CHK and FIN.
- CHK exists only with the macro (REQ-032).
REQ-019 SHALL transfer a byte only when in_valid && in_ready.
- in_ready SHALL be 1 exactly in HDR, DATA and CHK.
REQ-020 SHALL go from IDLE or FIN to HDR on start=1.
- On that transition: clear byte index, length, err and done.
- start in HDR, DATA or CHK SHALL be ignored.
REQ-021 In HDR SHALL accept 4 bytes, little-endian, forming a 32-bit length N.
- First accepted byte is N[7:0].
REQ-022 After the 4th header byte:
- N=0: go to FIN, or to CHK if the macro is defined.
- N>MAX_BYTES: go to FIN with err=1, no memory writes.
- Otherwise: go to DATA.
REQ-023 In DATA, each accepted byte k (k=0..N-1) SHALL produce exactly one write on the following cycle.
- mem_we=1, mem_addr=BASE_ADDR+k, mem_wdata=byte.
- Latency: exactly 1 cycle.
REQ-024 SHALL hold mem_we at 0 in every cycle without a write from REQ-023.
- mem_addr and mem_wdata hold their last values in those cycles.
REQ-025 After byte N-1 is accepted, SHALL leave DATA:
- to FIN without the macro;
- to CHK with it.
- The final write is issued in the first cycle of the new state.
REQ-026 SHALL hold the index in a counter wide enough for MAX_BYTES.
- mem_addr SHALL be computed modulo 2^A_WIDTH.
REQ-027 SHALL drive busy=1 in HDR, DATA and CHK, and 0 otherwise.
- done SHALL be 1 only in FIN.
REQ-028 SHALL drive cpu_rst=0 only in FIN with err=0, and 1 otherwise.
REQ-029 Stalls (in_valid=0) SHALL cause no state change and no write.

Reset
REQ-030 rst=1 at any clock edge SHALL force IDLE, including mid-load.
- Outputs SHALL be: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, cpu_rst=1.
- Counters and length SHALL be 0.
REQ-031 rst SHALL take priority over start and over any pending write.
- A write pending from the previous cycle SHALL be dropped.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined:
- Keep an 8-bit mod-256 sum of the payload bytes.
- In CHK, accept one trailing byte and go to FIN.
- err=1 if that byte differs from the sum.
- Payload writes already made are not undone.
REQ-033 Macro LOADER_CHECKSUM_EN undefined:
- No CHK state, no checksum logic, no trailing byte.
- err is set only by REQ-022.

Verification
REQ-034 Reset then start, stream 04 00 00 00 13 05 A0 00 (checksum off) -> writes to BFC00000..BFC00003 of 13,05,A0,00, each one cycle after acceptance; then done=1, err=0, cpu_rst=0.
REQ-035 Header 00 00 00 00 -> FIN with no mem_we pulse; done=1, err=0 (checksum off).
REQ-036 Header 01 10 00 00 (N=4097) -> done=1, err=1, cpu_rst=1, zero writes.
REQ-037 Payload of 3 bytes with in_valid toggled every other cycle -> exactly 3 writes at BFC00000..BFC00002; no write in stall cycles.
REQ-038 rst asserted after 2 of 4 payload bytes -> next cycle IDLE, cpu_rst=1, mem_we=0; a new start reloads from BFC00000.
REQ-039 With LOADER_CHECKSUM_EN, payload 01 02 03 then trailer 06 -> err=0; same payload with trailer 07 -> err=1, 3 writes made.
